// File: rtl/decoder_seq.sv
// Registered N-to-2^N decoder with one-hot, thermometer and auto-scan modes,
// fed through a valid/ready handshake.
module decoder_seq #(
  parameter int ENCODE_WIDTH = 2,
  parameter int DECODE_WIDTH = 2 ** ENCODE_WIDTH,
  parameter int DWELL_WIDTH  = 8,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ENCODE_WIDTH-1:0] in,
  input  logic                    scan_en,
  input  logic [DWELL_WIDTH-1:0]  dwell,
  output logic [DECODE_WIDTH-1:0] out,
  output logic                    out_valid,
  output logic                    scan_wrap,
  output logic                    err_range
);

  typedef enum logic [1:0] {M_ONEHOT, M_THERMO, M_SCAN, M_OFF} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SCAN, S_OFF} state_e;

  state_e                  r_state;
  logic [ENCODE_WIDTH-1:0] r_idx;
  logic [DWELL_WIDTH-1:0]  r_cnt;
  logic [DECODE_WIDTH-1:0] r_out;
  logic                    r_out_valid;
  logic                    r_wrap;
  logic                    r_err;

  logic                    w_scan_req;
  logic                    w_accept;
  logic                    w_in_oor;
  logic [ENCODE_WIDTH-1:0] w_idx_next;

  // Out-of-range indices decode to all zeros in either mode.
  function automatic logic [DECODE_WIDTH-1:0] decode(input logic [ENCODE_WIDTH-1:0] idx,
                                                     input logic thermo);
    logic [DECODE_WIDTH:0]   t;
    logic [DECODE_WIDTH-1:0] v;
    logic [DECODE_WIDTH-1:0] m;
    if (thermo) begin
      t = ((DECODE_WIDTH + 1)'(2) << idx) - (DECODE_WIDTH + 1)'(1);
      v = t[DECODE_WIDTH-1:0];
    end else begin
      v = DECODE_WIDTH'(1) << idx;
    end
    if (32'(idx) >= 32'(DECODE_WIDTH)) v = '0;
    m = {<<{v}};
    return MSB_FIRST ? m : v;
  endfunction

  assign in_ready   = ((r_state == S_IDLE) || (r_state == S_HOLD)) &&
                      ((mode == M_ONEHOT) || (mode == M_THERMO));
  assign w_accept   = in_valid && in_ready;
  assign w_scan_req = (mode == M_SCAN) && scan_en;
  assign w_in_oor   = 32'(in) >= 32'(DECODE_WIDTH);
  assign w_idx_next = (32'(r_idx) >= 32'(DECODE_WIDTH - 1)) ? '0 : r_idx + ENCODE_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_wrap      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
      if (mode == M_OFF) begin
        r_state     <= S_OFF;
        r_out       <= '0;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          S_OFF: begin
            r_state     <= S_IDLE;
            r_out       <= '0;
            r_out_valid <= 1'b0;
          end
          S_SCAN: begin
            if (!w_scan_req) begin
              r_state     <= S_IDLE;
              r_idx       <= '0;
              r_out       <= '0;
              r_out_valid <= 1'b0;
            end else if (r_cnt == '0) begin
              // Dwell is re-sampled at the start of every index.
              r_idx  <= w_idx_next;
              r_cnt  <= dwell;
              r_out  <= decode(w_idx_next, 1'b0);
              r_wrap <= (w_idx_next == '0);
            end else begin
              r_cnt <= r_cnt - DWELL_WIDTH'(1);
            end
          end
          S_IDLE, S_HOLD: begin
            if (w_scan_req) begin
              r_state     <= S_SCAN;
              r_idx       <= '0;
              r_cnt       <= dwell;
              r_out       <= decode(ENCODE_WIDTH'(0), 1'b0);
              r_out_valid <= 1'b1;
            end else if (w_accept) begin
              r_state     <= S_HOLD;
              r_idx       <= in;
              r_out       <= decode(in, mode == M_THERMO);
              r_out_valid <= 1'b1;
              r_err       <= w_in_oor;
            end else if (r_state == S_HOLD) begin
              r_out <= decode(r_idx, mode == M_THERMO);
            end else begin
              r_out       <= '0;
              r_out_valid <= 1'b0;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_out       <= '0;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign scan_wrap = r_wrap;
  assign err_range = r_err;

endmodule
